// File: rtl/rx_ds_se.sv
// -----------------------------------------------------------------------------
// rx_ds_se -- Data/Strobe serial line receiver, single-ended inputs.
//
// D and S are asynchronous to RxClk. Each line goes through a two-flop
// synchronizer. The synchronized pair (Ds, Ss) is then compared against the
// previous sample (Dr, Sr):
//   * exactly one line changed -> one bit received, value = Ds (Rx1 / Rx0)
//   * both lines changed       -> line error (RxErr)
// The decode passes through one register stage and then the output register.
// A strobe therefore appears after the third RxClk edge that follows the edge
// where the input change is first captured.
//
// An idle counter runs once the link is active. After TIMEOUT consecutive
// cycles with no transition, it sets the sticky RxDisc flag. While RxDisc is
// set, all strobes are suppressed.
//
// Parameters
//   TIMEOUT   transition-free RxClk cycles that declare disconnect (2..65535)
//
// Ports
//   RxClk     in   receive clock, rising edge, >= 4x the D/S bit rate
//   RxReset   in   asynchronous active-high reset
//   D, S      in   Data / Strobe lines (asynchronous)
//   Rx1       out  one-cycle strobe: a 1 bit was received
//   Rx0       out  one-cycle strobe: a 0 bit was received
//   RxErr     out  one-cycle strobe: D and S changed together
//   RxDisc    out  sticky disconnect flag
//   RxActive  out  set by the first transition after reset, sticky
// -----------------------------------------------------------------------------
module rx_ds_se #(
    parameter int TIMEOUT = 32
) (
    input  logic RxClk,
    input  logic RxReset,
    input  logic D,
    input  logic S,
    output logic Rx1,
    output logic Rx0,
    output logic RxErr,
    output logic RxDisc,
    output logic RxActive
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    // Synchronizers. Stage 1 may go metastable, so only stage 2 is used.
    logic d_meta, s_meta;
    logic d_sync, s_sync;

    // Reference: previous synchronized sample. After reset it is (0,0), which
    // matches the transmitter's idle line state.
    logic d_ref, s_ref;

    // Combinational decode of the current sample against the reference.
    logic d_chg, s_chg;
    logic dec_bit, dec_err, dec_val;

    // Registered decode (pipeline stage between decode and outputs).
    logic bit_q, err_q, val_q;

    // Idle / disconnect tracking.
    logic        trans;
    logic [15:0] idle_cnt;
    logic [15:0] idle_next;
    logic        disc_next;

    // ------------------------------------------------------------------
    // Synchronizer and reference register.
    // NOTE: sequential state is assigned with <= so that every flop samples
    // the pre-edge value of its source. With blocking assignments here,
    // d_sync would see the new d_meta in the same edge and the two-flop
    // synchronizer would collapse into a single flop.
    // ------------------------------------------------------------------
    always_ff @(posedge RxClk or posedge RxReset) begin
        if (RxReset) begin
            d_meta <= 1'b0;
            s_meta <= 1'b0;
            d_sync <= 1'b0;
            s_sync <= 1'b0;
            d_ref  <= 1'b0;
            s_ref  <= 1'b0;
        end else begin
            d_meta <= D;
            s_meta <= S;
            d_sync <= d_meta;
            s_sync <= s_meta;
            // The reference always follows the sample. This covers both
            // cases: after a single-line change, and after an error, where
            // the new (Ds, Ss) pair becomes the reference.
            d_ref  <= d_sync;
            s_ref  <= s_sync;
        end
    end

    // ------------------------------------------------------------------
    // Decode.
    // NOTE: every always_comb output gets its default value first. Any path
    // that left a variable unassigned would infer a latch.
    // ------------------------------------------------------------------
    always_comb begin
        d_chg   = 1'b0;
        s_chg   = 1'b0;
        dec_bit = 1'b0;
        dec_err = 1'b0;
        dec_val = 1'b0;

        d_chg   = d_sync ^ d_ref;
        s_chg   = s_sync ^ s_ref;
        dec_bit = d_chg ^ s_chg;
        dec_err = d_chg & s_chg;
        dec_val = d_sync;
    end

    // Decode pipeline register.
    always_ff @(posedge RxClk or posedge RxReset) begin
        if (RxReset) begin
            bit_q <= 1'b0;
            err_q <= 1'b0;
            val_q <= 1'b0;
        end else begin
            bit_q <= dec_bit;
            err_q <= dec_err;
            val_q <= dec_val;
        end
    end

    // ------------------------------------------------------------------
    // Idle counter and disconnect detection. Both use the registered
    // decode, so they update on the same edge as the strobes.
    // If a transition arrives on the edge where the count would reach
    // TIMEOUT, the transition wins: the counter clears and RxDisc stays low.
    // The counter only advances while RxActive is set, so an idle line after
    // reset can never raise RxDisc.
    // ------------------------------------------------------------------
    always_comb begin
        trans     = bit_q | err_q;
        idle_next = idle_cnt;
        disc_next = RxDisc;

        if (trans) begin
            idle_next = '0;
        end else if (RxActive && (idle_cnt != TMO)) begin
            // idle_cnt < TMO <= 65535, so the increment cannot wrap.
            idle_next = idle_cnt + 16'd1;
            if (idle_next == TMO) begin
                disc_next = 1'b1;
            end
        end
    end

    // Output register. The strobes are gated by the current RxDisc.
    // On the edge that sets RxDisc there is no transition by construction,
    // so no strobe can coincide with the flag rising.
    always_ff @(posedge RxClk or posedge RxReset) begin
        if (RxReset) begin
            Rx1      <= 1'b0;
            Rx0      <= 1'b0;
            RxErr    <= 1'b0;
            RxDisc   <= 1'b0;
            RxActive <= 1'b0;
            idle_cnt <= '0;
        end else begin
            Rx1      <= bit_q &  val_q & ~RxDisc;
            Rx0      <= bit_q & ~val_q & ~RxDisc;
            RxErr    <= err_q & ~RxDisc;
            RxDisc   <= disc_next;
            RxActive <= RxActive | trans;
            idle_cnt <= idle_next;
        end
    end

endmodule

// File: tb/tb_rx_ds_se.sv
// -----------------------------------------------------------------------------
// tb_rx_ds_se -- self-checking bench for rx_ds_se (TIMEOUT = 8).
//
// The reference model keeps a short history of the (D,S) pairs captured at
// each rising edge. The outputs after edge m are a function of the samples
// captured at edges m-3 and m-4: a single-line change is a bit, a double
// change is an error. A plain idle count decides disconnect.
// A compare process checks every output on every falling edge. Directed
// scenarios add hand-computed expectations on pulse position and count.
// -----------------------------------------------------------------------------
module tb_rx_ds_se;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    logic d_line, s_line;
    logic rx1, rx0, rx_err, rx_disc, rx_active;

    int tests  = 0;
    int errors = 0;

    rx_ds_se #(.TIMEOUT(TMO)) dut (
        .RxClk    (clk),
        .RxReset  (rst),
        .D        (d_line),
        .S        (s_line),
        .Rx1      (rx1),
        .Rx0      (rx0),
        .RxErr    (rx_err),
        .RxDisc   (rx_disc),
        .RxActive (rx_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] hist [0:3];  // hist[k] = (D,S) captured k edges ago
    logic m_rx1 = 1'b0, m_rx0 = 1'b0, m_err = 1'b0, m_disc = 1'b0, m_act = 1'b0;
    int   m_idle = 0;

    initial for (int i = 0; i < 4; i++) hist[i] = 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= 2'b00;
            m_rx1  <= 1'b0;
            m_rx0  <= 1'b0;
            m_err  <= 1'b0;
            m_disc <= 1'b0;
            m_act  <= 1'b0;
            m_idle <= 0;
        end else begin
            logic [1:0] newer, older;
            logic dchg, schg, ev_bit, ev_err;
            newer  = hist[2];   // sample from edge m-3
            older  = hist[3];   // sample from edge m-4
            dchg   = newer[1] != older[1];
            schg   = newer[0] != older[0];
            ev_bit = dchg != schg;
            ev_err = dchg && schg;

            m_rx1 <= ev_bit &&  newer[1] && !m_disc;
            m_rx0 <= ev_bit && !newer[1] && !m_disc;
            m_err <= ev_err && !m_disc;

            if (ev_bit || ev_err) begin
                m_idle <= 0;
                m_act  <= 1'b1;
            end else if (m_act && m_idle < TMO) begin
                m_idle <= m_idle + 1;
                if (m_idle + 1 == TMO) m_disc <= 1'b1;
            end

            hist[0] <= {d_line, s_line};
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    function automatic int dut_outs();
        return int'({27'd0, rx1, rx0, rx_err, rx_disc, rx_active});
    endfunction

    function automatic int model_outs();
        return int'({27'd0, m_rx1, m_rx0, m_err, m_disc, m_act});
    endfunction

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("cycle_outputs{rx1,rx0,err,disc,act}", dut_outs(), model_outs());
        check("strobe_onehot", int'($countones({rx1, rx0, rx_err}) <= 1), 1);
    end

    // ---------------- directed helpers ----------------
    int w_rx1, w_rx0, w_err, w_first, w_disc;

    // Observe n edges, sampling #1 after each. k = 1 is the first edge.
    task automatic watch(input int n);
        w_rx1 = 0; w_rx0 = 0; w_err = 0; w_first = 0; w_disc = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (rx1)    w_rx1++;
            if (rx0)    w_rx0++;
            if (rx_err) w_err++;
            if ((rx1 || rx0 || rx_err) && w_first == 0) w_first = k;
            if (rx_disc && w_disc == 0) w_disc = k;
        end
    endtask

    // Change the lines at a falling edge, then watch. The next rising edge
    // (k = 1) is the first one to capture the change.
    task automatic drive_watch(input logic d, input logic s, input int n);
        @(negedge clk);
        d_line = d;
        s_line = s;
        watch(n);
    endtask

    // Reset with the given line state held; returns at the deasserting
    // falling edge.
    task automatic reset_dut(input logic d, input logic s);
        @(negedge clk);
        rst    = 1'b1;
        d_line = d;
        s_line = s;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] seq_ds  [0:3];
        logic [1:0] seq_exp [0:3];  // {rx1 count, rx0 count}

        rst    = 1'b1;
        d_line = 1'b0;
        s_line = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_outs(), 0);
        rst = 1'b0;

        // S rises -> Rx0 three edges after capture; then D rises -> Rx1.
        reset_dut(1'b0, 1'b0);
        drive_watch(1'b0, 1'b0, 5);
        check("idle00_no_strobe", w_rx1 + w_rx0 + w_err, 0);
        check("idle00_inactive", int'(rx_active), 0);
        drive_watch(1'b0, 1'b1, 6);
        check("s_rise_rx0_count", w_rx0, 1);
        check("s_rise_rx0_edge", w_first, 4);
        check("s_rise_no_rx1", w_rx1 + w_err, 0);
        check("s_rise_active", int'(rx_active), 1);
        drive_watch(1'b1, 1'b1, 6);
        check("d_rise_rx1_count", w_rx1, 1);
        check("d_rise_rx1_edge", w_first, 4);

        // (1,0),(1,1),(1,0),(0,0) -> Rx1,Rx1,Rx1,Rx0.
        seq_ds[0]  = 2'b10; seq_ds[1]  = 2'b11; seq_ds[2]  = 2'b10; seq_ds[3]  = 2'b00;
        seq_exp[0] = 2'b10; seq_exp[1] = 2'b10; seq_exp[2] = 2'b10; seq_exp[3] = 2'b01;
        reset_dut(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_watch(seq_ds[i][1], seq_ds[i][0], 4);
            check("seq_rx1", w_rx1, int'(seq_exp[i][1]));
            check("seq_rx0", w_rx0, int'(seq_exp[i][0]));
            check("seq_no_err", w_err, 0);
            check("seq_edge", w_first, 4);
        end

        // 00 -> 11 is an error; then 11 -> 01 is a 0 bit.
        reset_dut(1'b0, 1'b0);
        drive_watch(1'b1, 1'b1, 6);
        check("both_err_count", w_err, 1);
        check("both_err_edge", w_first, 4);
        check("both_no_bit", w_rx1 + w_rx0, 0);
        drive_watch(1'b0, 1'b1, 6);
        check("after_err_rx0", w_rx0, 1);
        check("after_err_only", w_rx1 + w_err, 0);

        // Disconnect exactly TIMEOUT cycles after the bit's strobe cycle.
        reset_dut(1'b0, 1'b0);
        drive_watch(1'b0, 1'b1, 14);
        check("disc_bit_edge", w_first, 4);
        check("disc_edge", w_disc, 4 + TMO);

        // A transition on the edge the count would reach TIMEOUT wins.
        reset_dut(1'b0, 1'b0);
        drive_watch(1'b0, 1'b1, 8);
        check("late_trans_no_disc_yet", w_disc, 0);
        drive_watch(1'b1, 1'b1, 13);
        check("late_trans_rx1_edge", w_first, 4);
        check("late_trans_rx1_count", w_rx1, 1);
        check("late_trans_disc_restart", w_disc, 4 + TMO);

        // Idle lines after reset never disconnect.
        reset_dut(1'b0, 1'b0);
        drive_watch(1'b0, 1'b0, 100);
        check("long_idle_no_disc", w_disc, 0);
        check("long_idle_inactive", int'(rx_active), 0);

        // While disconnected, line activity produces no strobes.
        drive_watch(1'b0, 1'b1, 14);
        check("disc_set", int'(rx_disc), 1);
        drive_watch(1'b1, 1'b1, 6);
        drive_watch(1'b1, 1'b0, 6);
        check("disc_strobes_blocked", w_rx1 + w_rx0 + w_err, 0);
        check("disc_sticky", int'(rx_disc), 1);
        check("disc_active_kept", int'(rx_active), 1);

        // Reset in the middle of a strobe, then no stray pulse afterwards.
        reset_dut(1'b0, 1'b0);
        drive_watch(1'b1, 1'b0, 4);
        check("mid_strobe_rx1_high", int'(rx1), 1);
        #1 rst = 1'b1;
        #1 check("mid_strobe_reset_outputs", dut_outs(), 0);
        d_line = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        watch(8);
        check("post_reset_no_strobe", w_rx1 + w_rx0 + w_err, 0);

        // Lines already high when reset releases: differences from (0,0).
        reset_dut(1'b1, 1'b1);
        watch(6);
        check("release_11_err", w_err, 1);
        check("release_11_edge", w_first, 4);
        reset_dut(1'b1, 1'b0);
        watch(6);
        check("release_10_rx1", w_rx1, 1);

        // Randomized traffic, including double changes, long idles and resets.
        for (int it = 0; it < 300; it++) begin
            if (it % 60 == 0) reset_dut(1'b0, 1'b0);
            drive_watch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(1, 10));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
